status_update_ctrl: RTL and testbench

- Producer side of the STATUS register: computes the next STATUS byte and drives the register's write strobe and data.
- Sequences one update per 4-phase instruction cycle (Q1–Q4) and merges three sources: ALU flags (Z, DC, C), direct software writes to STATUS, and core events (SLEEP, CLRWDT, WDT timeout).
- Sits between the decode/ALU datapath and the STATUS register.

---
 rtl/pic_status_pkg.sv | 16 +
 rtl/status_flag_merge.sv | 25 ++
 rtl/status_update_ctrl.sv | 100 ++++++++++
 tb/tb_status_update_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_status_pkg.sv
// pic_status_pkg: STATUS bit positions, flag_mask layout, controller states and POR constant.
package pic_status_pkg;
   localparam int IRP   = 7;
   localparam int RP_HI = 6;
   localparam int RP_LO = 5;
   localparam int N_TO  = 4;
   localparam int N_PD  = 3;
   localparam int Z     = 2;
   localparam int DC    = 1;
   localparam int C     = 0;
   localparam int FM_Z  = 2;
   localparam int FM_DC = 1;
   localparam int FM_C  = 0;
   localparam logic [7:0] POR_DEFAULT = 8'h18;
   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_Q1, ST_Q2, ST_Q3, ST_Q4, ST_EVT} state_t;
endpackage

// File: rtl/status_flag_merge.sv
// status_flag_merge: combinational next-STATUS byte from base, software data, ALU flags and core events.
module status_flag_merge
   import pic_status_pkg::*;
(
   input  logic [7:0] base,
   input  logic [7:0] alu_result,
   input  logic       file_wr,
   input  logic [2:0] flag_mask,
   input  logic       alu_dc,
   input  logic       alu_c,
   input  logic       evt_sleep,
   input  logic       evt_clrwdt,
   input  logic       evt_wdt_to,
   output logic [7:0] next_status
);
   always_comb begin
      next_status[IRP:RP_LO] = file_wr ? alu_result[IRP:RP_LO] : base[IRP:RP_LO];
      next_status[N_TO] = evt_wdt_to ? 1'b0 : (evt_sleep || evt_clrwdt) ? 1'b1 : base[N_TO];
      next_status[N_PD] = evt_sleep ? 1'b0 : evt_clrwdt ? 1'b1 : base[N_PD];
      // flag updates win over the software write of the same bit
      next_status[Z]  = flag_mask[FM_Z] ? (alu_result == 8'h00) : file_wr ? alu_result[Z] : base[Z];
      next_status[DC] = flag_mask[FM_DC] ? alu_dc : file_wr ? alu_result[DC] : base[DC];
      next_status[C]  = flag_mask[FM_C] ? alu_c : file_wr ? alu_result[C] : base[C];
   end
endmodule

// File: rtl/status_update_ctrl.sv
// status_update_ctrl: one STATUS update per Q1-Q4 instruction cycle plus the POR write after reset.
// STATUS_UPD_WDT_EN adds sticky SLEEP/CLRWDT/WDT event capture and the standalone EVT write state.
module status_update_ctrl
   import pic_status_pkg::*;
#(
   parameter logic [7:0] POR_VALUE = POR_DEFAULT,
   parameter int         DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [2:0]        flag_mask,
   input  logic              stat_file_wr,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_dc,
   input  logic              alu_c,
   input  logic              evt_sleep,
   input  logic              evt_clrwdt,
   input  logic              evt_wdt_to,
   input  logic [7:0]        status_cur,
   output logic              status_wr,
   output logic [7:0]        status_reg_in,
   output logic              busy
);
   state_t            state, state_nxt;
   logic [2:0]        mask_q;
   logic              fwr_q, dc_q, c_q;
   logic [DATA_W-1:0] res_q;
   logic [7:0]        hold_q, merged;
   logic [2:0]        pend;
   logic              in_q4;
   always_ff @(posedge clk)
      if (rst) state <= ST_INIT;
      else state <= state_nxt;
   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: begin
`ifdef STATUS_UPD_WDT_EN
            state_nxt = instr_valid ? ST_Q1 : (|pend) ? ST_EVT : ST_IDLE;
`else
            state_nxt = instr_valid ? ST_Q1 : ST_IDLE;
`endif
         end
         ST_Q1:   state_nxt = ST_Q2;
         ST_Q2:   state_nxt = ST_Q3;
         ST_Q3:   state_nxt = ST_Q4;
         ST_Q4:   state_nxt = instr_valid ? ST_Q1 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end
   always_comb begin
      in_q4 = (state == ST_Q4);
      status_wr = !rst && (state == ST_INIT || state == ST_EVT || (in_q4 && (|mask_q || fwr_q || |pend)));
      status_reg_in = !status_wr ? hold_q : (state == ST_INIT) ? POR_VALUE : merged;
      busy = (state != ST_IDLE);
   end
   always_ff @(posedge clk)
      if (rst) begin
         mask_q <= 3'b000;
         fwr_q  <= 1'b0;
         res_q  <= '0;
         dc_q   <= 1'b0;
         c_q    <= 1'b0;
         hold_q <= 8'h00;
      end else begin
         if (instr_valid && (state == ST_IDLE || state == ST_Q4)) begin
            mask_q <= flag_mask;
            fwr_q  <= stat_file_wr;
         end
         if (state == ST_Q3) begin
            res_q <= alu_result;
            dc_q  <= alu_dc;
            c_q   <= alu_c;
         end
         hold_q <= status_reg_in;
      end
`ifdef STATUS_UPD_WDT_EN
   // {wdt_to, sleep, clrwdt}; a pulse landing in the consuming cycle survives the clear
   always_ff @(posedge clk)
      if (rst) pend <= 3'b000;
      else pend <= ((state == ST_Q4 || state == ST_EVT) ? 3'b000 : pend) | {evt_wdt_to, evt_sleep, evt_clrwdt};
`else
   logic unused_evt;
   assign pend = 3'b000;
   assign unused_evt = ^{evt_wdt_to, evt_sleep, evt_clrwdt};
`endif
   status_flag_merge u_merge (
      .base        (status_cur),
      .alu_result  (res_q),
      .file_wr     (fwr_q && in_q4),
      .flag_mask   (in_q4 ? mask_q : 3'b000),
      .alu_dc      (dc_q),
      .alu_c       (c_q),
      .evt_sleep   (pend[1]),
      .evt_clrwdt  (pend[0]),
      .evt_wdt_to  (pend[2]),
      .next_status (merged)
   );
endmodule

// File: tb/tb_status_update_ctrl.sv
// tb_status_update_ctrl: randomized and directed checks of status_update_ctrl against an instruction-level model.
module tb_status_update_ctrl;
`ifdef STATUS_UPD_WDT_EN
   localparam bit WDT_EN = 1'b1;
`else
   localparam bit WDT_EN = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst, instr_valid, stat_file_wr, alu_dc, alu_c;
   logic       evt_sleep, evt_clrwdt, evt_wdt_to, status_wr, busy;
   logic [2:0] flag_mask;
   logic [7:0] alu_result, status_cur, status_reg_in;
   int         vectors = 0;
   int         miscompares = 0;
   logic       prev_valid = 1'b0;
   logic       prev_w = 1'b0;
   logic [7:0] prev_d = 8'h00;
   logic [7:0] last_d = 8'h00;
   always #5 clk = ~clk;
   status_update_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .flag_mask     (flag_mask),
      .stat_file_wr  (stat_file_wr),
      .alu_result    (alu_result),
      .alu_dc        (alu_dc),
      .alu_c         (alu_c),
      .evt_sleep     (evt_sleep),
      .evt_clrwdt    (evt_clrwdt),
      .evt_wdt_to    (evt_wdt_to),
      .status_cur    (status_cur),
      .status_wr     (status_wr),
      .status_reg_in (status_reg_in),
      .busy          (busy)
   );
   // ev = {wdt_to, sleep, clrwdt}; events applied in ascending priority so later ones override
   function automatic logic [7:0] model_status(input logic [7:0] cur, input logic [2:0] m, input logic fw,
                                               input logic [7:0] r, input logic dc, input logic c, input logic [2:0] ev);
      logic [7:0] s;
      s = fw ? ((r & 8'hE7) | (cur & 8'h18)) : cur;
      if (m[2]) s[2] = (r == 8'h00);
      if (m[1]) s[1] = dc;
      if (m[0]) s[0] = c;
      if (ev[0]) s = s | 8'h18;
      if (ev[1]) s = (s | 8'h10) & 8'hF7;
      if (ev[2]) s = s & 8'hEF;
      return s;
   endfunction
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic set_evt(input logic [2:0] ev);
      {evt_wdt_to, evt_sleep, evt_clrwdt} = ev;
   endtask
   // entered just after the edge that starts an IDLE cycle, or a Q4 cycle when chaining
   task automatic do_instr(input logic [2:0] m, input logic fw, input logic [7:0] r, input logic dc, input logic c,
                           input logic [7:0] cur, input logic [2:0] ev_q1, input logic [2:0] ev_q4, input bit chain);
      logic [2:0] ev;
      logic       ew;
      logic [7:0] ed;
      ev = WDT_EN ? ev_q1 : 3'b000;
      set_evt(3'b000);
      instr_valid = 1'b1;
      flag_mask = m;
      stat_file_wr = fw;
      @(negedge clk);
      vectors++;
      if (prev_valid) begin
         if (status_wr !== prev_w || busy !== 1'b1 || status_reg_in !== prev_d) begin
            miscompares++;
            $display("FAIL chain_q4: wr=%b busy=%b d=%h want wr=%b busy=1 d=%h", status_wr, busy, status_reg_in, prev_w, prev_d);
         end
      end else if ({status_wr, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL issue_idle: wr/busy=%b want 00", {status_wr, busy});
      end
      cyc();
      instr_valid = 1'b0;
      flag_mask = 3'($urandom);
      stat_file_wr = 1'($urandom);
      status_cur = cur;
      set_evt(ev_q1);
      for (int q = 1; q <= 3; q++) begin
         if (q == 3) begin
            alu_result = r;
            alu_dc = dc;
            alu_c = c;
         end
         @(negedge clk);
         vectors++;
         if ({status_wr, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL q%0d_nowrite: wr/busy=%b want 01", q, {status_wr, busy});
         end
         cyc();
         set_evt(3'b000);
      end
      alu_result = 8'($urandom);
      alu_dc = 1'($urandom);
      alu_c = 1'($urandom);
      set_evt(ev_q4);
      ew = (m != 3'b000) || fw || (ev != 3'b000);
      ed = ew ? model_status(cur, m, fw, r, dc, c, ev) : last_d;
      last_d = ed;
      if (chain) begin
         prev_valid = 1'b1;
         prev_w = ew;
         prev_d = ed;
      end else begin
         prev_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if (status_wr !== ew || busy !== 1'b1 || status_reg_in !== ed) begin
            miscompares++;
            $display("FAIL q4_write: wr=%b busy=%b d=%h want wr=%b busy=1 d=%h", status_wr, busy, status_reg_in, ew, ed);
         end
         cyc();
         set_evt(3'b000);
         @(negedge clk);
         vectors++;
         if ({status_wr, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL back_idle: wr/busy=%b want 00", {status_wr, busy});
         end
         cyc();
      end
   endtask
   task automatic test_reset();
      cyc();
      cyc();
      @(negedge clk);
      vectors++;
      if ({status_wr, busy, status_reg_in} !== {2'b01, 8'h00}) begin
         miscompares++;
         $display("FAIL in_reset: wr/busy/d=%b/%b/%h want 0/1/00", status_wr, busy, status_reg_in);
      end
      cyc();
      rst = 1'b0;
      instr_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ({status_wr, busy, status_reg_in} !== {2'b11, 8'h18}) begin
         miscompares++;
         $display("FAIL init_write: wr/busy/d=%b/%b/%h want 1/1/18", status_wr, busy, status_reg_in);
      end
      cyc();
      instr_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vectors++;
         if ({status_wr, busy, status_reg_in} !== {2'b00, 8'h18}) begin
            miscompares++;
            $display("FAIL post_init: wr/busy/d=%b/%b/%h want 0/0/18", status_wr, busy, status_reg_in);
         end
         cyc();
      end
      last_d = 8'h18;
   endtask
   task automatic test_flags();
      do_instr(3'b111, 1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 3'b000, 3'b000, 1'b0);
      do_instr(3'b100, 1'b1, 8'hE0, 1'b0, 1'b0, 8'h1F, 3'b000, 3'b000, 1'b0);
      do_instr(3'b011, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0);
   endtask
   task automatic test_gating();
      do_instr(3'b000, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h18, 3'b000, 3'b000, 1'b0);
   endtask
   task automatic test_events();
      logic [2:0] ev_t [4] = '{3'b110, 3'b001, 3'b010, 3'b100};
      logic [7:0] cur_t [4] = '{8'h18, 8'h00, 8'h1F, 8'h1F};
      logic [7:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         status_cur = cur_t[i];
         set_evt(ev_t[i]);
         cyc();
         set_evt(3'b000);
         @(negedge clk);
         vectors++;
         if ({status_wr, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL evt_wait: wr/busy=%b want 00", {status_wr, busy});
         end
         cyc();
         exp_d = WDT_EN ? model_status(cur_t[i], 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, ev_t[i]) : last_d;
         @(negedge clk);
         vectors++;
         if (status_wr !== WDT_EN || busy !== WDT_EN || status_reg_in !== exp_d) begin
            miscompares++;
            $display("FAIL evt_write%0d: wr=%b busy=%b d=%h want wr=%b busy=%b d=%h", i, status_wr, busy, status_reg_in, WDT_EN, WDT_EN, exp_d);
         end
         last_d = exp_d;
         cyc();
         @(negedge clk);
         vectors++;
         if ({status_wr, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL evt_cleared: wr/busy=%b want 00", {status_wr, busy});
         end
         cyc();
      end
      do_instr(3'b000, 1'b0, 8'h33, 1'b0, 1'b0, 8'h18, 3'b010, 3'b000, 1'b0);
      do_instr(3'b001, 1'b0, 8'h55, 1'b0, 1'b1, 8'h18, 3'b000, 3'b100, 1'b0);
      exp_d = WDT_EN ? 8'h08 : last_d;
      @(negedge clk);
      vectors++;
      if (status_wr !== WDT_EN || status_reg_in !== exp_d) begin
         miscompares++;
         $display("FAIL q4_evt_kept: wr=%b d=%h want wr=%b d=%h", status_wr, status_reg_in, WDT_EN, exp_d);
      end
      last_d = exp_d;
      cyc();
      cyc();
   endtask
   task automatic test_back_to_back();
      do_instr(3'b001, 1'b0, 8'h01, 1'b0, 1'b1, 8'h18, 3'b000, 3'b000, 1'b1);
      do_instr(3'b110, 1'b0, 8'h00, 1'b1, 1'b0, 8'h19, 3'b000, 3'b000, 1'b1);
      do_instr(3'b000, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h1E, 3'b000, 3'b000, 1'b0);
   endtask
   task automatic test_random();
      for (int i = 0; i < 40; i++)
         do_instr(3'($urandom), 1'($urandom), (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)),
                  1'($urandom), 1'($urandom), 8'($urandom),
                  (($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000), 3'b000,
                  (i < 39) && ($urandom_range(0, 1) == 1));
   endtask
   task automatic test_reset_mid();
      instr_valid = 1'b1;
      flag_mask = 3'b111;
      stat_file_wr = 1'b0;
      status_cur = 8'h18;
      cyc();
      instr_valid = 1'b0;
      cyc();
      cyc();
      alu_result = 8'h00;
      alu_dc = 1'b1;
      alu_c = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (status_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_q3: wr=%b want 0", status_wr);
      end
      cyc();
      @(negedge clk);
      vectors++;
      if ({status_wr, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL mid_no_q4: wr/busy=%b want 01", {status_wr, busy});
      end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({status_wr, status_reg_in} !== {1'b1, 8'h18}) begin
         miscompares++;
         $display("FAIL mid_init: wr/d=%b/%h want 1/18", status_wr, status_reg_in);
      end
      cyc();
      last_d = 8'h18;
      do_instr(3'b100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h18, 3'b000, 3'b000, 1'b0);
   endtask
   initial begin
      rst = 1'b1;
      instr_valid = 1'b0;
      flag_mask = 3'b000;
      stat_file_wr = 1'b0;
      alu_result = 8'h00;
      alu_dc = 1'b0;
      alu_c = 1'b0;
      set_evt(3'b000);
      status_cur = 8'h18;
      test_reset();
      test_flags();
      test_gating();
      test_events();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
